// File: rtl/ctrl_pipeline_elastic_if.sv
// ----------------------------------------------------------------------------
// ctrl_pipeline_elastic_if
//   Handshake and data bundle for the elastic control pipeline that travels
//   alongside the AES round datapath.
//
//   Signals (spec names kept):
//     vin, tin, din   upstream valid / type tag / data word  (source -> pipe)
//     rdy_in          pipeline can accept this cycle          (pipe -> source)
//     flush           synchronous flush of all entries        (source -> pipe)
//     rdy_out         downstream ready                        (sink -> pipe)
//     vout,tout,dout  output valid / type tag / data word     (pipe -> sink)
//     occ             number of valid stages                  (pipe -> all)
//     perr            parity error pulse (CTRL_PIPE_PARITY_EN builds only)
//
//   Modports: master = environment driving the pipeline, slave = the pipeline.
//   Optional macro: CTRL_PIPE_PARITY_EN adds the perr signal.
// ----------------------------------------------------------------------------
`default_nettype none

interface ctrl_pipeline_elastic_if #(
  parameter int DEPTH = 10,
  parameter int DW    = 128,
  parameter int TW    = 1,
  localparam int CW   = $clog2(DEPTH + 1)
);

  logic          vin;
  logic [TW-1:0] tin;
  logic [DW-1:0] din;
  logic          rdy_in;
  logic          flush;
  logic          rdy_out;
  logic          vout;
  logic [TW-1:0] tout;
  logic [DW-1:0] dout;
  logic [CW-1:0] occ;
`ifdef CTRL_PIPE_PARITY_EN
  logic          perr;

  modport master (
    output vin, tin, din, flush, rdy_out,
    input  rdy_in, vout, tout, dout, occ, perr
  );

  modport slave (
    input  vin, tin, din, flush, rdy_out,
    output rdy_in, vout, tout, dout, occ, perr
  );
`else
  modport master (
    output vin, tin, din, flush, rdy_out,
    input  rdy_in, vout, tout, dout, occ
  );

  modport slave (
    input  vin, tin, din, flush, rdy_out,
    output rdy_in, vout, tout, dout, occ
  );
`endif

endinterface

`default_nettype wire

// File: rtl/ctrl_pipeline_elastic.sv
// ----------------------------------------------------------------------------
// ctrl_pipeline_elastic
//   Parametrised elastic delay line carrying {valid, type tag, data word}
//   next to the AES round pipeline. DEPTH register stages give a zero-stall
//   latency of DEPTH cycles. Downstream backpressure stalls only contiguous
//   valid stages, so bubbles collapse toward the output. A synchronous flush
//   drops every in-flight entry, and a registered occupancy count tracks how
//   many stages hold live blocks.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-low reset
//     bus   ctrl_pipeline_elastic_if.slave (vin/tin/din/rdy_in, flush,
//           rdy_out/vout/tout/dout, occ, and perr when parity is enabled)
//
//   Parameters: DEPTH (>=1), DW data width, TW tag width, CW derived.
//   Optional macro: CTRL_PIPE_PARITY_EN -- each stage carries XOR(tag,data)
//   computed at stage 0; perr pulses one cycle after an output transfer
//   whose recomputed parity disagrees with the carried bit.
// ----------------------------------------------------------------------------
`default_nettype none

module ctrl_pipeline_elastic #(
  parameter int DEPTH = 10,
  parameter int DW    = 128,
  parameter int TW    = 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  ctrl_pipeline_elastic_if.slave   bus
);

  // Stage 0 is the input side, stage DEPTH-1 drives the outputs.
  logic [DEPTH-1:0]          v_q, v_d;
  logic [DEPTH-1:0][TW-1:0]  t_q, t_d;
  logic [DEPTH-1:0][DW-1:0]  d_q, d_d;
  logic [CW-1:0]             occ_q, occ_d;
  logic [DEPTH-1:0]          en;
  logic                      accept;
  logic                      xfer;
`ifdef CTRL_PIPE_PARITY_EN
  logic [DEPTH-1:0]          p_q, p_d;
  logic                      perr_q, perr_d;
`endif

  // A stage may advance when it is empty or the stage ahead advances; the
  // chain starts at the output with downstream ready. A stall therefore only
  // reaches back through an unbroken run of valid stages.
  always_comb begin : enable_chain
    logic nxt;
    en  = '0;
    nxt = bus.rdy_out;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      nxt   = ~v_q[k] | nxt;
      en[k] = nxt;
    end
  end

  // The flush-cycle input is dropped even when rdy_in is high.
  assign accept = bus.vin & en[0] & ~bus.flush;
  assign xfer   = v_q[DEPTH-1] & bus.rdy_out;

  // NOTE: every signal driven here gets its hold value first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin : next_state
    v_d = v_q;
    t_d = t_q;
    d_d = d_q;

    // Tag/data load whenever the stage advances, valid or not; contents of
    // an invalid stage are don't-care.
    if (en[0]) begin
      v_d[0] = bus.vin;
      t_d[0] = bus.tin;
      d_d[0] = bus.din;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (en[k]) begin
        v_d[k] = v_q[k-1];
        t_d[k] = t_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end

    // Flush wins over every other update; an output transfer in the same
    // cycle has already been presented to the sink and still completes.
    if (bus.flush) begin
      v_d   = '0;
      occ_d = '0;
    end else begin
      occ_d = occ_q + CW'(accept) - CW'(xfer);
    end
  end

`ifdef CTRL_PIPE_PARITY_EN
  always_comb begin : parity_next
    p_d = p_q;
    if (en[0]) begin
      p_d[0] = ^{bus.tin, bus.din};
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (en[k]) begin
        p_d[k] = p_q[k-1];
      end
    end
    if (bus.flush) begin
      p_d = '0;
    end
    perr_d = xfer & ((^{t_q[DEPTH-1], d_q[DEPTH-1]}) != p_q[DEPTH-1]);
  end
`endif

  // NOTE: state registers use non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the shift is order-free.
  // NOTE: the tag/data arrays are reset as well, because the outputs are
  // required to read zero out of reset and after an asynchronous abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q    <= '0;
      t_q    <= '0;
      d_q    <= '0;
      occ_q  <= '0;
`ifdef CTRL_PIPE_PARITY_EN
      p_q    <= '0;
      perr_q <= 1'b0;
`endif
    end else begin
      v_q    <= v_d;
      t_q    <= t_d;
      d_q    <= d_d;
      occ_q  <= occ_d;
`ifdef CTRL_PIPE_PARITY_EN
      p_q    <= p_d;
      perr_q <= perr_d;
`endif
    end
  end

  assign bus.rdy_in = en[0];
  assign bus.vout   = v_q[DEPTH-1];
  assign bus.tout   = t_q[DEPTH-1];
  assign bus.dout   = d_q[DEPTH-1];
  assign bus.occ    = occ_q;
`ifdef CTRL_PIPE_PARITY_EN
  assign bus.perr   = perr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipeline_elastic.sv
// ----------------------------------------------------------------------------
// tb_ctrl_pipeline_elastic
//   Directed bench for ctrl_pipeline_elastic: reset state, zero-stall latency
//   and ordering, full-pipe backpressure, bubble collapsing, flush, async
//   reset mid-stream, and (CTRL_PIPE_PARITY_EN, DEPTH=4) parity error pulse.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ctrl_pipeline_elastic;

`ifdef CTRL_PIPE_PARITY_EN
  localparam int D  = 4;
`else
  localparam int D  = 10;
`endif
  localparam int DW = 128;
  localparam int TW = 1;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ctrl_pipeline_elastic_if #(.DEPTH(D), .DW(DW), .TW(TW)) bus ();

  ctrl_pipeline_elastic #(.DEPTH(D), .DW(DW), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

`ifdef CTRL_PIPE_PARITY_EN
  logic [D-1:0][DW-1:0] dsnap;
`endif

  initial begin
    int               acc;
    int               nf;
    int               nr;
    logic             seen;
    logic [D-1:0]     exp_v;

    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b0;
    bus.vin     = 1'b0;
    bus.tin     = '0;
    bus.din     = '0;
    bus.flush   = 1'b0;
    bus.rdy_out = 1'b0;

    // ---------------- reset state
    #1;
    check("rst_vout",   128'(bus.vout),   128'(0));
    check("rst_tout",   128'(bus.tout),   128'(0));
    check("rst_dout",   bus.dout,         128'(0));
    check("rst_occ",    128'(bus.occ),    128'(0));
    check("rst_rdy_in", 128'(bus.rdy_in), 128'(1));
`ifdef CTRL_PIPE_PARITY_EN
    check("rst_perr",   128'(bus.perr),   128'(0));
`endif
    #11 rst = 1'b1;

    // ---------------- latency and ordering, rdy_out high
    bus.rdy_out = 1'b1;
    #1;
    for (int i = 0; i < D; i++) begin
      bus.vin = 1'b1;
      bus.din = 128'(i + 1);
      bus.tin = TW'(i % 2);
      check("fill_rdy_in", 128'(bus.rdy_in), 128'(1));
      cyc();
      // first accept at edge 1 appears after edge D
      check("lat_vout", 128'(bus.vout), 128'(i == D - 1));
    end
    check("peak_occ", 128'(bus.occ), 128'(D));
    bus.vin = 1'b0;
    for (int i = 0; i < D; i++) begin
      check("drain_vout", 128'(bus.vout), 128'(1));
      check("drain_dout", bus.dout,       128'(i + 1));
      check("drain_tout", 128'(bus.tout), 128'(i % 2));
      cyc();
    end
    check("empty_vout", 128'(bus.vout), 128'(0));
    check("empty_occ",  128'(bus.occ),  128'(0));

    // ---------------- fill against stalled output
    bus.rdy_out = 1'b0;
    acc = 0;
    for (int i = 0; i < D + 5; i++) begin
      bus.vin = 1'b1;
      bus.din = 128'(100 + acc);
      #1;
      if (bus.rdy_in) acc++;
      cyc();
    end
    check("full_accepts", 128'(acc),        128'(D));
    check("full_rdy_in",  128'(bus.rdy_in), 128'(0));
    check("full_occ",     128'(bus.occ),    128'(D));
    check("full_dout",    bus.dout,         128'(100));
    bus.rdy_out = 1'b1;
    bus.din     = 128'(100 + acc);
    #1;
    check("passthru_rdy_in", 128'(bus.rdy_in), 128'(1));
    cyc();
    bus.rdy_out = 1'b0;
    #1;
    check("swap_occ",    128'(bus.occ),    128'(D));
    check("swap_dout",   bus.dout,         128'(101));
    check("swap_rdy_in", 128'(bus.rdy_in), 128'(0));
    bus.vin   = 1'b0;
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    check("clean1_occ",  128'(bus.occ),  128'(0));
    check("clean1_vout", 128'(bus.vout), 128'(0));

    // ---------------- bubble collapsing
    for (int i = 0; i < 20; i++) begin
      bus.vin = (i < 4) && (i % 2 == 0);
      bus.din = 128'(200 + i);
      cyc();
    end
    exp_v        = '0;
    exp_v[D-1]   = 1'b1;
    exp_v[D-2]   = 1'b1;
    check("bub_occ",    128'(bus.occ),    128'(2));
    check("bub_rdy_in", 128'(bus.rdy_in), 128'(1));
    check("bub_dout",   bus.dout,         128'(200));
    check("bub_stages", 128'(dut.v_q),    128'(exp_v));
    bus.rdy_out = 1'b1;
    cyc();
    bus.rdy_out = 1'b0;
    check("bub_next_dout", bus.dout,      128'(202));
    check("bub_next_occ",  128'(bus.occ), 128'(1));
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    check("clean2_occ", 128'(bus.occ), 128'(0));

    // ---------------- flush drops in-flight and same-cycle input
    nf = (D >= 7) ? 6 : D - 1;
    for (int i = 0; i < nf; i++) begin
      bus.vin = 1'b1;
      bus.din = 128'(300 + i);
      cyc();
    end
    check("preflush_occ", 128'(bus.occ), 128'(nf));
    bus.vin   = 1'b1;
    bus.din   = 128'hBAD;
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    bus.vin   = 1'b0;
    check("flush_vout",   128'(bus.vout),   128'(0));
    check("flush_occ",    128'(bus.occ),    128'(0));
    check("flush_rdy_in", 128'(bus.rdy_in), 128'(1));
    bus.rdy_out = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < D + 2; i++) begin
      if (bus.vout) seen = 1'b1;
      cyc();
    end
    check("flush_no_output", 128'(seen), 128'(0));

    // ---------------- asynchronous reset mid-stream
    bus.rdy_out = 1'b0;
    nr = (D >= 6) ? 5 : D - 1;
    bus.tin = 1'b1;
    for (int i = 0; i < nr; i++) begin
      bus.vin = 1'b1;
      bus.din = 128'(400 + i);
      cyc();
    end
    bus.vin = 1'b0;
    bus.tin = 1'b0;
    repeat (D) cyc();
    check("prerst_occ",  128'(bus.occ),  128'(nr));
    check("prerst_vout", 128'(bus.vout), 128'(1));
    check("prerst_tout", 128'(bus.tout), 128'(1));
    check("prerst_dout", bus.dout,       128'(400));
    #2 rst = 1'b0;
    #1;
    check("arst_vout", 128'(bus.vout), 128'(0));
    check("arst_tout", 128'(bus.tout), 128'(0));
    check("arst_dout", bus.dout,       128'(0));
    check("arst_occ",  128'(bus.occ),  128'(0));
    #2 rst = 1'b1;
    #1;
    check("arst_rdy_in", 128'(bus.rdy_in), 128'(1));
    cyc();

`ifdef CTRL_PIPE_PARITY_EN
    // ---------------- parity error on a corrupted stage
    bus.rdy_out = 1'b0;
    for (int i = 0; i < D; i++) begin
      bus.vin = 1'b1;
      bus.din = 128'(500 + i);
      bus.tin = TW'(i % 2);
      cyc();
    end
    bus.vin = 1'b0;
    check("par_full_occ", 128'(bus.occ),  128'(D));
    check("par_pre_perr", 128'(bus.perr), 128'(0));
    dsnap       = dut.d_q;
    dsnap[2][0] = ~dsnap[2][0];
    force dut.d_q = dsnap;
    #1;
    release dut.d_q;
    bus.rdy_out = 1'b1;
    // stage 2 holds the entry that transfers at edge D-2
    for (int j = 1; j <= D + 1; j++) begin
      cyc();
      check("par_perr", 128'(bus.perr), 128'(j == D - 2));
    end
    bus.rdy_out = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_pipeline_elastic.md
Name: ctrl_pipeline_elastic

Overview:
- Parametrised successor to the fixed 10-round AES control delay line.
- Carries valid, type (encrypt/decrypt or key/data tag) and a data word alongside the round datapath, with configurable depth and widths.
- Adds downstream backpressure with bubble collapsing, a synchronous flush, and an occupancy count.
- Sits between the AES input interface and the round pipeline, tracking which round stages hold live blocks.

Parameters:
DEPTH, 10, number of register stages (>=1); zero-stall latency in cycles.
DW, 128, data word width.
TW, 1, type/tag width.
CW, $clog2(DEPTH+1), occupancy count width (derived; do not override).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
vin  input  1  input valid.
tin  input  TW  input type/tag.
din  input  DW  input data.
rdy_in  output  1  pipeline can accept this cycle.
flush  input  1  synchronous flush; drops all in-flight entries.
rdy_out  input  1  downstream ready.
vout  output  1  output valid.
tout  output  TW  output type/tag.
dout  output  DW  output data.
occ  output  CW  number of valid stages.

Behaviour:
- Stage state: v[k], t[k], d[k] for k = 0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 drives vout/tout/dout directly.
- Reset (rst low, async): all v, t, d = 0; hence vout=0, tout=0, dout=0, occ=0. rdy_in=1 after reset (combinational from empty state).
- Advance enables (combinational):
  - en[DEPTH-1] = !v[DEPTH-1] | rdy_out.
  - en[k] = !v[k] | en[k+1].
  - rdy_in = en[0].
- Stage update on clk when en[k]=1:
  - Stage k loads stage k-1; stage 0 loads {vin, tin, din}.
  - When en[k]=0, stage k holds.
- Accept: vin & rdy_in. Output transfer: vout & rdy_out.
- Latency: with rdy_out held high, an input accepted at edge n appears on vout after edge n+DEPTH-1. DEPTH registers total, matching the legacy 10-cycle delay at the default.
- Bubble collapsing: an invalid stage always accepts. A stall propagates upstream only through contiguous valid stages. Empty slots ahead of a stalled output fill up.
- Data/type of an invalid stage are don't-care. Implement them as loading unconditionally when en[k]=1 (no valid gating), as the legacy block did.
- Occupancy:
  - occ is a registered count, updated each cycle by +1 on accept and -1 on output transfer; simultaneous accept and transfer leaves it unchanged.
  - occ always equals popcount(v).
  - occ never exceeds DEPTH; rdy_in=0 exactly when occ==DEPTH and rdy_out=0.
- Flush:
  - At the next edge, all v=0 and occ=0.
  - An input presented in the same cycle is dropped, even if rdy_in=1.
  - An output transfer in the flush cycle still completes: downstream sees it if rdy_out=1.
  - Flush has priority over all other updates.
- rdy_out low with empty pipeline: no effect.
- vin while rdy_in=0: not accepted; the source must hold.
- Reset mid-operation: all entries are lost immediately, asynchronously. No output glitch beyond vout falling.
- DEPTH=1: behaves as a single-entry pipeline register with pass-through ready: rdy_in = !v[0] | rdy_out.

Optional Feature:
CTRL_PIPE_PARITY_EN
- Defined:
  - Each stage carries an extra parity bit: XOR of tin and din, computed at stage 0.
  - A new output perr (1 bit, reset 0) is added.
  - perr is registered and asserts for one cycle following any output transfer whose recomputed XOR(tout, dout) mismatches the carried parity.
  - Flush clears the parity bits along with the valids.
- Undefined: no parity storage, no perr port.
- Datapath latency and handshake are identical in both builds.

Test Plan:
- Reset, then vin=1 with din=128'h0001..0A on 10 consecutive cycles, rdy_out=1 -> first vout one cycle after the 10th edge following first accept; dout sequence matches in order; occ peaks at 10; rdy_in stays 1.
- Fill with rdy_out=0, vin=1 continuously -> exactly 10 accepts, then rdy_in=0, occ=10. Raise rdy_out for 1 cycle -> one transfer, one accept, occ stays 10.
- Bubbles: vin pattern 1,0,1,0 with rdy_out=0 for 20 cycles -> both entries collapse to stages 9 and 8; occ=2; rdy_in remains 1.
- Flush with occ=6 while vin=1, rdy_out=0 -> next cycle vout=0, occ=0, and the flush-cycle input is never output.
- Assert rst low asynchronously mid-stream with occ=5 -> vout, tout, dout and occ go to 0 without a clock edge; after release, rdy_in=1.
- With CTRL_PIPE_PARITY_EN and DEPTH=4: force a bit flip in d[2] via the bench -> perr=1 for one cycle after that entry transfers; clean entries keep perr=0.
